// File: rtl/multi_ch_accumulator.sv
// Multi-channel signed accumulator. Each channel sums beats over a window closed by in_last.
// A flush request drains every channel, in ascending order, through the same result register.
module multi_ch_accumulator #(
    parameter int                          DATA_WIDTH = 16,
    parameter int                          ACC_WIDTH  = 32,
    parameter int                          NUM_CH     = 4,
    parameter int                          CH_W       = $clog2(NUM_CH),
    parameter logic signed [ACC_WIDTH-1:0] ACC_INIT   = '0,
    parameter int                          SATURATE   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              in_ch,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    input  logic                         flush_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_ch,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic                         out_sat,
    output logic                         busy
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CH_W:0]               CH_LIMIT = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0]             LAST_CH  = CH_W'(NUM_CH - 1);

    // Returns {overflow, result}; the sum is formed one bit wider so overflow is visible.
    function automatic logic [ACC_WIDTH:0] sat_add(
        input logic signed [ACC_WIDTH-1:0]  a,
        input logic signed [DATA_WIDTH-1:0] d
    );
        logic signed [ACC_WIDTH:0]   s;
        logic signed [ACC_WIDTH-1:0] r;
        logic                        ovf;
        s   = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
        ovf = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
        if (ovf && (SATURATE != 0))
            r = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            r = s[ACC_WIDTH-1:0];
        return {ovf, r};
    endfunction

    state_t                      state, state_nxt;
    logic [CH_W-1:0]             flush_ch;
    logic signed [ACC_WIDTH-1:0] acc [NUM_CH];
    logic [NUM_CH-1:0]           sat;

    logic                        out_free, in_fire, ch_ok, beat_fire, load_beat, drain_fire;
    logic signed [ACC_WIDTH-1:0] cur_acc, drain_acc, beat_sum;
    logic                        cur_sat, drain_sat, beat_ovf;

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = rst_n && (state == RUN) && out_free;
    assign busy       = (state == FLUSH);
    assign in_fire    = in_valid && in_ready;
    assign ch_ok      = ({1'b0, in_ch} < CH_LIMIT);
    assign beat_fire  = in_fire && ch_ok;
    assign load_beat  = beat_fire && in_last;
    assign drain_fire = (state == FLUSH) && out_free;

    // Channel select muxes for the incoming beat and the channel being drained.
    always_comb begin
        cur_acc   = ACC_INIT;
        cur_sat   = 1'b0;
        drain_acc = ACC_INIT;
        drain_sat = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                cur_acc = acc[i];
                cur_sat = sat[i];
            end
            if (flush_ch == CH_W'(i)) begin
                drain_acc = acc[i];
                drain_sat = sat[i];
            end
        end
    end

    assign {beat_ovf, beat_sum} = sat_add(cur_acc, in_data);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_req) state_nxt = FLUSH;
            FLUSH:   if (drain_fire && (flush_ch == LAST_CH)) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            flush_ch <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN || (drain_fire && flush_ch == LAST_CH))
                flush_ch <= '0;
            else if (drain_fire)
                flush_ch <= flush_ch + 1'b1;
        end
    end

    // Accumulator bank: a closing beat or a drain reloads the channel and clears its sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= ACC_INIT;
                sat[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (beat_fire && (in_ch == CH_W'(i))) begin
                    if (in_last) begin
                        acc[i] <= ACC_INIT;
                        sat[i] <= 1'b0;
                    end else begin
                        acc[i] <= beat_sum;
                        sat[i] <= sat[i] | beat_ovf;
                    end
                end else if (drain_fire && (flush_ch == CH_W'(i))) begin
                    acc[i] <= ACC_INIT;
                    sat[i] <= 1'b0;
                end
            end
        end
    end

    // Result register: holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (load_beat) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= beat_sum;
            out_sat   <= cur_sat | beat_ovf;
        end else if (drain_fire) begin
            out_valid <= 1'b1;
            out_ch    <= flush_ch;
            out_data  <= drain_acc;
            out_sat   <= drain_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
